// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage hazard fields toward the controller,
// forwarding selects and stall information back to the pipeline.
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_count
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects, load-use stall and a
// saturating stall counter, tracking only register indices of in-flight ops.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_ctrl_if.slave bus
);
    // Slot flags are stored already qualified as writers (valid, reg_write, rd != 0).
    // The W2 slot needs no storage: select 11 is decided while its entry sits in WB.
    logic              ex_wr, ex_ld, mem_wr, wb_wr, take;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic [1:0]        sel_a, sel_b;

    assign bus.stall = bus.id_valid & ~bus.flush & ex_wr & ex_ld &
                       ((bus.id_use_rs1 & (bus.id_rs1 == ex_rd)) | (bus.id_use_rs2 & (bus.id_rs2 == ex_rd)));
    assign take = bus.id_valid & ~bus.stall & ~bus.flush;

    always_comb begin
        sel_a = ~bus.id_use_rs1 ? 2'b00 :
                (ex_wr & ~ex_ld & (bus.id_rs1 == ex_rd)) ? 2'b01 :
                (mem_wr & (bus.id_rs1 == mem_rd)) ? 2'b10 :
                (wb_wr & (bus.id_rs1 == wb_rd)) ? 2'b11 : 2'b00;
        sel_b = ~bus.id_use_rs2 ? 2'b00 :
                (ex_wr & ~ex_ld & (bus.id_rs2 == ex_rd)) ? 2'b01 :
                (mem_wr & (bus.id_rs2 == mem_rd)) ? 2'b10 :
                (wb_wr & (bus.id_rs2 == wb_rd)) ? 2'b11 : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wr           <= 1'b0;
            ex_ld           <= 1'b0;
            ex_rd           <= '0;
            mem_wr          <= 1'b0;
            mem_rd          <= '0;
            wb_wr           <= 1'b0;
            wb_rd           <= '0;
            bus.fwd_a_sel   <= 2'b00;
            bus.fwd_b_sel   <= 2'b00;
            bus.stall_count <= '0;
        end else begin
            ex_wr         <= take & bus.id_reg_write & (|bus.id_rd);
            ex_ld         <= take & bus.id_mem_read;
            ex_rd         <= bus.id_rd;
            mem_wr        <= ex_wr;
            mem_rd        <= ex_rd;
            wb_wr         <= mem_wr;
            wb_rd         <= mem_rd;
            bus.fwd_a_sel <= take ? sel_a : 2'b00;
            bus.fwd_b_sel <= take ? sel_b : 2'b00;
            if (bus.stall && !(&bus.stall_count))
                bus.stall_count <= bus.stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed vector table, saturation and reset sequences,
// then random traffic against a distance-based forwarding model.
module tb_fwd_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
    fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int v, rs1, rs2, u1, u2, rd, rw, mr, fl;
        int est, ea, eb, ecnt;
    } vec_t;
    typedef struct {
        bit wr;
        int rd;
        bit ld;
    } ent_t;

    ent_t hist[$];
    int   mcnt;
    int   pass_n = 0;
    int   total_n = 0;
    vec_t tbl[$];

    task automatic check(string nm, int act, int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(int v, int rs1, int rs2, int u1, int u2, int rd, int rw, int mr, int fl,
                                int est, int ea, int eb, int ecnt);
        vec_t r;
        r = '{v, rs1, rs2, u1, u2, rd, rw, mr, fl, est, ea, eb, ecnt};
        return r;
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < 3; i++) hist.push_back('{1'b0, 0, 1'b0});
        mcnt = 0;
    endtask

    // Expected select = distance to the youngest matching writer (1..3); distance-1 loads stall instead.
    function automatic int msel(int u, int rs);
        if (u == 0) return 0;
        for (int d = 0; d < 3; d++)
            if (hist[d].wr && hist[d].rd == rs) return (d == 0 && hist[d].ld) ? 0 : d + 1;
        return 0;
    endfunction

    function automatic bit mstall(vec_t r);
        return r.v != 0 && r.fl == 0 && hist[0].wr && hist[0].ld &&
               ((r.u1 != 0 && r.rs1 == hist[0].rd) || (r.u2 != 0 && r.rs2 == hist[0].rd));
    endfunction

    task automatic drive(vec_t r);
        bus.id_valid     = r.v[0];
        bus.id_rs1       = AW'(r.rs1);
        bus.id_rs2       = AW'(r.rs2);
        bus.id_use_rs1   = r.u1[0];
        bus.id_use_rs2   = r.u2[0];
        bus.id_rd        = AW'(r.rd);
        bus.id_reg_write = r.rw[0];
        bus.id_mem_read  = r.mr[0];
        bus.flush        = r.fl[0];
    endtask

    // One pipeline cycle; expectations come from the table row or from the model.
    task automatic tick(bit use_tbl, vec_t r);
        bit st, tk;
        int ea, eb;
        drive(r);
        st = mstall(r);
        tk = r.v != 0 && !st && r.fl == 0;
        ea = tk ? msel(r.u1, r.rs1) : 0;
        eb = tk ? msel(r.u2, r.rs2) : 0;
        #3;
        check("stall", int'(bus.stall), use_tbl ? r.est : int'(st));
        @(posedge clk);
        hist.push_front('{tk && r.rw != 0 && r.rd != 0, r.rd, r.mr != 0});
        hist.delete(3);
        if (st && mcnt < CMAX) mcnt++;
        #1;
        check("fwd_a_sel", int'(bus.fwd_a_sel), use_tbl ? r.ea : ea);
        check("fwd_b_sel", int'(bus.fwd_b_sel), use_tbl ? r.eb : eb);
        check("stall_count", int'(bus.stall_count), use_tbl ? r.ecnt : mcnt);
    endtask

    initial begin
        vec_t add5, nop, sub;
        add5 = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        nop  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sub  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        drive(nop);
        model_reset();
        #2;
        check("rst_a", int'(bus.fwd_a_sel), 0);
        check("rst_b", int'(bus.fwd_b_sel), 0);
        check("rst_stall", int'(bus.stall), 0);
        check("rst_cnt", int'(bus.stall_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // distance 1..4 forwarding
        tbl.push_back(add5);
        sub.ea = 1; sub.eb = 1; tbl.push_back(sub);
        tbl.push_back(add5); tbl.push_back(nop);
        sub.ea = 2; sub.eb = 2; tbl.push_back(sub);
        tbl.push_back(add5); tbl.push_back(nop); tbl.push_back(nop);
        sub.ea = 3; sub.eb = 3; tbl.push_back(sub);
        tbl.push_back(add5); tbl.push_back(nop); tbl.push_back(nop); tbl.push_back(nop);
        sub.ea = 0; sub.eb = 0; tbl.push_back(sub);
        // load-use: exactly one stall, then MEM forwarding of the load
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 2, 0, 1));
        // x0 writer/reader and unused rs2
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 9, 1, 0, 4, 1, 0, 0, 0, 0, 0, 1));
        // flush beats load-use
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 10, 0, 1, 0, 11, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 10, 0, 1, 0, 11, 1, 0, 0, 0, 2, 0, 1));
        // back-to-back writers: youngest wins
        add5.ecnt = 1; tbl.push_back(add5); tbl.push_back(add5);
        tbl.push_back(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 2, 2, 1));
        foreach (tbl[i]) tick(1'b1, tbl[i]);

        // lw x7,0(x7) repeated: stalls every other cycle, counter must saturate
        for (int i = 0; i < 41; i++) tick(1'b0, mk(1, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0));
        check("sat_cnt", int'(bus.stall_count), CMAX);

        // reset in the middle of live forwarding and a pending stall
        tick(1'b0, mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0));
        tick(1'b0, mk(1, 5, 5, 1, 1, 7, 1, 1, 0, 0, 0, 0, 0));
        drive(mk(1, 7, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0));
        #2;
        check("pre_rst_stall", int'(bus.stall), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_a", int'(bus.fwd_a_sel), 0);
        check("mid_rst_b", int'(bus.fwd_b_sel), 0);
        check("mid_rst_stall", int'(bus.stall), 0);
        check("mid_rst_cnt", int'(bus.stall_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tick(1'b0, mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0));
        check("post_rst_a", int'(bus.fwd_a_sel), 0);

        // random traffic on a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            vec_t r;
            r = mk(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 1 : 0,
                   0, 0, 0, 0);
            tick(1'b0, r);
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the EX-stage operand muxes of the pipelined RISC-V core. It tracks the destination registers of in-flight instructions and drives the 2-bit selects of the two 4-input, 32-bit operand multiplexers (operand A and operand B). It also raises the load-use stall to IF/ID and inserts bubbles into ID/EX. It sits beside the ID/EX pipeline register and holds no datapath values, only register indices and control flags.

## Interface
- `REG_AW`, 5, register index width.
- `CNT_W`, 16, width of the stall performance counter.

- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_AW  source registers of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction actually reads rs1/rs2.
- `id_rd`  in  REG_AW  destination of the ID instruction.
- `id_reg_write`  in  1  the ID instruction writes `id_rd`.
- `id_mem_read`  in  1  the ID instruction is a load.
- `flush`  in  1  branch/jump taken, resolved in EX; squashes IF and ID.
- `fwd_a_sel`, `fwd_b_sel`  out  2  operand mux selects, registered:
  - 00: register file
  - 01: EX/MEM ALU result
  - 10: MEM/WB writeback value
  - 11: WB+1 value, the value written to the register file last cycle
- `stall`  out  1  hold PC and IF/ID (combinational).
- `stall_count`  out  CNT_W  saturating count of stall cycles.

## Operation
- The block keeps an internal tracker of four stage slots: EX, MEM, WB and W2. Each slot holds valid, rd, reg_write and mem_read.
  - EX also holds rs1/rs2 and their use flags.
- **Slot update, every rising edge:**
  - W2←WB, WB←MEM, MEM←EX.
  - EX←ID fields when `id_valid & !stall & !flush`; otherwise EX←bubble (all flags 0).
- **Writer qualification:** a slot counts as a writer only if valid & reg_write & rd≠0. x0 is never forwarded.
- **Stall:** `stall` = id_valid & !flush & EX is a writer & EX.mem_read & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- **Select computation:** computed for the instruction entering EX, from ID source fields compared against the slots that will be MEM/WB/W2 next cycle (current EX/MEM/WB). Per operand:
  - priority 01 (current EX writer, non-load) > 10 (current MEM writer) > 11 (current WB writer) > 00.
  - If the use flag is 0, select 00.
  - A load in current EX never yields 01; that case is covered by the stall.
- **Select register update:**
  - When EX receives a bubble (stall or flush), the selects register 00.
  - Otherwise they register the computed value.
- **Stall counter:** `stall_count` increments on every edge where `stall`=1 and saturates at all-ones.

## Timing
- **Reset** (asynchronous, immediate): all slots invalid, `fwd_a_sel`=`fwd_b_sel`=00, `stall_count`=0, so `stall`=0.
- **Select latency:** selects are valid from the edge where the instruction enters EX, and are stable for its whole EX cycle.
- **Stall behaviour:** `stall` depends only on current-cycle inputs and slot state. A single load-use produces exactly one stall cycle. The stalled instruction enters EX one cycle later with select 10 from the load.
- **Flush priority:** `flush` and a stall condition in the same cycle: flush wins, `stall`=0, and EX gets a bubble.
- **No duplicate writers:** back-to-back writers to the same rd forward from the youngest (priority order).
- **Reset mid-operation:** all in-flight state is discarded; nothing forwards until new instructions pass ID.

## Test plan
- **Reset:** assert `rst` mid-stream. Required: selects immediately 00, `stall`=0, `stall_count`=0; the first post-reset instruction gets selects 00.
- **Distance-1 to 3 forwarding:** `add x5` followed by `sub x6,x5,x5` at distance 1, 2 and 3. Required: `fwd_a_sel`=`fwd_b_sel` = 01, 10 and 11 respectively; at distance 4 they are 00.
- **Load-use:** `lw x7` followed by `add x8,x7,x1`. Required: `stall`=1 for exactly one cycle, then `fwd_a_sel`=10, `fwd_b_sel`=00, and `stall_count`=1.
- **x0 and unused sources:** a writer to x0, then a reader of x0. Required: selects 00. A load to x9 followed by an instruction with `id_use_rs2`=0 and `id_rs2`=9 must not stall.
- **Flush vs stall:** a load-use condition with `flush`=1 in the same cycle. Required: `stall`=0, EX is a bubble, next selects 00, and `stall_count` is unchanged.
- **Counter saturation:** with CNT_W=4, force 20 stall cycles. Required: `stall_count` holds 15.
